instr_sequencer: RTL and testbench

//   Fetch/decode/sequence stage feeding the opcode-to-alu_sel control unit.

---
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 tb/tb_instr_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/sequence stage: fetches 8-bit instructions over a req/ack port,
// drives operands from a 4x8 register file to the ALU and writes results back.
module instr_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ld_en,
    input  logic [1:0]        ld_idx,
    input  logic [7:0]        ld_data,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_data,
    output logic [2:0]        opcode,
    output logic [7:0]        opa,
    output logic [7:0]        opb,
    output logic              alu_start,
    input  logic [7:0]        alu_result,
    input  logic              alu_done,
    output logic              cmp_flag,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err,
    input  logic [1:0]        dbg_idx,
    output logic [7:0]        dbg_data
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT, ERR
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t     state, state_nx;
    logic [7:0] regs [4];
    logic [7:0] instr;
    logic [7:0] result;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        alu_start = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (imem_ack) state_nx = DECODE;
            end
            DECODE: begin
                busy     = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                busy      = 1'b1;
                alu_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // Completion wins over the timeout when both land on the same cycle
                if (alu_done)                          state_nx = WB;
                else if (wait_cnt + 8'd1 == WAIT_LIM)  state_nx = ERR;
            end
            WB: begin
                busy     = 1'b1;
                state_nx = instr[0] ? HALT : FETCH;
            end
            ERR: begin
                err = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= '0;
            instr    <= '0;
            opcode   <= '0;
            opa      <= '0;
            opb      <= '0;
            result   <= '0;
            cmp_flag <= 1'b0;
            wait_cnt <= '0;
            regs     <= '{default: '0};
        end else begin
            unique case (state)
                IDLE, HALT: begin
                    if (ld_en) regs[ld_idx] <= ld_data;
                    if (start) pc <= '0;
                end
                FETCH: begin
                    if (imem_ack) instr <= imem_data;
                end
                DECODE: begin
                    opcode <= instr[7:5];
                    opa    <= regs[instr[4:3]];
                    opb    <= regs[instr[2:1]];
                end
                EXEC: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (alu_done) result   <= alu_result;
                    else          wait_cnt <= wait_cnt + 8'd1;
                end
                WB: begin
                    if (opcode == 3'b111) cmp_flag          <= result[0];
                    else                  regs[instr[4:3]] <= result;
                    pc <= pc + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_addr = pc;
        dbg_data  = regs[dbg_idx];
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: bench-owned memory and ALU responders feed an
// instruction-level model; a per-cycle compare plus directed end-state checks.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, ld_en;
    logic [1:0] ld_idx, dbg_idx;
    logic [7:0] ld_data, imem_data, alu_result, dbg_data, opa, opb;
    logic       imem_req, imem_ack, alu_start, alu_done, cmp_flag, busy, halted, err;
    logic [7:0] imem_addr, pc;
    logic [2:0] opcode;

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(8), .WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ld_en(ld_en), .ld_idx(ld_idx),
        .ld_data(ld_data), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .opcode(opcode), .opa(opa),
        .opb(opb), .alu_start(alu_start), .alu_result(alu_result),
        .alu_done(alu_done), .cmp_flag(cmp_flag), .pc(pc), .busy(busy),
        .halted(halted), .err(err), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] imem [256];
    int   ack_delay, done_delay, fetch_cycles, n_starts, req_cnt, wcnt;
    bit   done_never, stray, patch_en, pend, prev_start;
    logic [7:0] patch_val;

    // Instruction-level model: register file, pc, compare flag, halt status
    logic [7:0] m_r [4];
    logic [7:0] m_pc;
    bit         m_cmp, m_halt;
    logic [7:0] m_ins, m_a, m_b, m_res;
    logic [2:0] m_op;
    logic [1:0] m_rd, m_rs;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a * b;
            3'd6:    return a >> 1;
            default: return {7'd0, a > b};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory and ALU responders; they act 2ns after the edge, after the test drivers
    initial begin
        imem_ack = 1'b0; imem_data = '0; alu_done = 1'b0; alu_result = '0;
        forever begin
            @(posedge clk); #2;
            imem_ack = 1'b0;
            alu_done = 1'b0;
            if (!rst_n) begin
                req_cnt = 0;
                pend    = 1'b0;
            end else if (stray) begin
                imem_ack = 1'b1;
                alu_done = 1'b1;
            end else begin
                if (imem_req) begin
                    fetch_cycles++;
                    if (req_cnt >= ack_delay) begin
                        imem_ack  = 1'b1;
                        imem_data = imem[imem_addr];
                        m_ins     = imem[m_pc];
                        req_cnt   = 0;
                        if (patch_en && m_pc == 8'd0) begin
                            imem[0]  = patch_val;
                            patch_en = 1'b0;
                        end
                    end else begin
                        req_cnt++;
                    end
                end
                if (alu_start) begin
                    n_starts++;
                    m_op  = m_ins[7:5];
                    m_rd  = m_ins[4:3];
                    m_rs  = m_ins[2:1];
                    m_a   = m_r[m_rd];
                    m_b   = m_r[m_rs];
                    m_res = alu_fn(m_op, m_a, m_b);
                    wcnt  = done_delay;
                    pend  = 1'b1;
                end else if (pend) begin
                    wcnt--;
                    if (wcnt <= 0 && !done_never) begin
                        alu_done   = 1'b1;
                        alu_result = m_res;
                        pend       = 1'b0;
                        if (m_op == 3'b111) m_cmp = m_res[0];
                        else                m_r[m_rd] = m_res;
                        m_pc = m_pc + 8'd1;
                        if (m_ins[0]) m_halt = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("status_exclusive", 32'($countones({busy, halted, err}) <= 1), 1);
            if (imem_req) chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
            if (alu_start) begin
                chk("start_single", 32'(prev_start), 0);
                chk("exec_opcode", 32'(opcode), 32'(m_op));
                chk("exec_opa", 32'(opa), 32'(m_a));
                chk("exec_opb", 32'(opb), 32'(m_b));
            end else if (pend) begin
                chk("hold_opcode", 32'(opcode), 32'(m_op));
                chk("hold_opa", 32'(opa), 32'(m_a));
                chk("hold_opb", 32'(opb), 32'(m_b));
            end
        end
        prev_start = alu_start;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; ld_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_r = '{default: '0};
        m_pc = '0; m_cmp = 1'b0; m_halt = 1'b0;
    endtask

    task automatic preload(input logic [1:0] idx, input logic [7:0] d, input bit model);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_idx = idx; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        if (model) m_r[idx] = d;
    endtask

    task automatic run_prog(input int budget, input bit busy_ld, input bit with_ld,
                            input logic [1:0] li, input logic [7:0] lv, output int cyc);
        @(posedge clk); #1;
        start = 1'b1; m_pc = '0; m_halt = 1'b0;
        if (with_ld) begin
            ld_en = 1'b1; ld_idx = li; ld_data = lv;
            m_r[li] = lv;
        end
        cyc = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0; ld_en = 1'b0;
            cyc++;
            if (busy_ld && cyc == 2) begin
                ld_en = 1'b1; ld_idx = 2'd0; ld_data = 8'h55;
            end
        end while (!halted && !err && cyc < budget);
        ld_en = 1'b0;
        chk("run_in_budget", 32'(halted | err), 1);
    endtask

    task automatic check_all(input string tag, input bit exp_err);
        for (int i = 0; i < 4; i++) begin
            dbg_idx = 2'(i); #1;
            chk({tag, "_reg"}, 32'(dbg_data), 32'(m_r[i]));
        end
        chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
        chk({tag, "_cmp"}, 32'(cmp_flag), 32'(m_cmp));
        chk({tag, "_halted"}, 32'(halted), 32'(m_halt));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic check_reset(input string tag);
        check_all(tag, 1'b0);
        chk({tag, "_req"}, 32'(imem_req), 0);
        chk({tag, "_alu_start"}, 32'(alu_start), 0);
        chk({tag, "_opcode"}, 32'(opcode), 0);
        chk({tag, "_opa"}, 32'(opa), 0);
        chk({tag, "_opb"}, 32'(opb), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [7:0] v);
        dbg_idx = idx; #1;
        v = dbg_data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [7:0] v;
        rst_n = 1'b0; start = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0; dbg_idx = '0;
        ack_delay = 0; done_delay = 1; done_never = 1'b0; stray = 1'b0;
        patch_en = 1'b0; patch_val = '0; fetch_cycles = 0; n_starts = 0;
        req_cnt = 0; wcnt = 0; pend = 1'b0; prev_start = 1'b0;
        m_ins = '0; m_op = '0; m_rd = '0; m_rs = '0; m_a = '0; m_b = '0; m_res = '0;
        for (int i = 0; i < 256; i++) imem[i] = '0;

        do_reset();
        check_reset("reset");

        // add R1,R2 (last): minimum-latency instruction
        preload(2'd1, 8'd5, 1'b1);
        preload(2'd2, 8'd3, 1'b1);
        imem[0] = 8'b000_01_10_1;
        run_prog(100, 1'b0, 1'b0, 2'd0, 8'd0, cyc);
        chk("t1_instr_cycles", 32'(cyc - 1), 5);
        check_all("t1", 1'b0);
        read_reg(2'd1, v);
        chk("t1_r1_literal", 32'(v), 8);
        chk("t1_pc_literal", 32'(pc), 1);
        chk("t1_halted_literal", 32'(halted), 1);

        // sub R2,R1 with fetch ack delayed 4 cycles
        ack_delay = 4; fetch_cycles = 0;
        imem[0] = 8'b001_10_01_1;
        run_prog(100, 1'b0, 1'b0, 2'd0, 8'd0, cyc);
        chk("t2_fetch_cycles", 32'(fetch_cycles), 5);
        chk("t2_total_cycles", 32'(cyc), 10);
        check_all("t2", 1'b0);
        read_reg(2'd2, v);
        chk("t2_r2_literal", 32'(v), 8'hFB);
        ack_delay = 0;

        // mul R1,R1 with done 6 cycles after alu_start
        done_delay = 6; n_starts = 0;
        imem[0] = 8'b101_01_01_1;
        run_prog(100, 1'b0, 1'b0, 2'd0, 8'd0, cyc);
        chk("t3_start_pulses", 32'(n_starts), 1);
        chk("t3_total_cycles", 32'(cyc), 11);
        check_all("t3", 1'b0);
        read_reg(2'd1, v);
        chk("t3_r1_literal", 32'(v), 64);
        done_delay = 1;

        // preload R3=7 in the same cycle as start; add R3,R3
        imem[0] = 8'b000_11_11_1;
        run_prog(100, 1'b0, 1'b1, 2'd3, 8'd7, cyc);
        check_all("t4", 1'b0);
        read_reg(2'd3, v);
        chk("t4_r3_literal", 32'(v), 14);

        // compare then add R0,R0; a preload attempt while busy must be dropped
        do_reset();
        preload(2'd1, 8'd5, 1'b1);
        preload(2'd2, 8'd3, 1'b1);
        imem[0] = 8'b111_01_10_0;
        imem[1] = 8'b000_00_00_1;
        run_prog(100, 1'b1, 1'b0, 2'd0, 8'd0, cyc);
        check_all("t5", 1'b0);
        chk("t5_cmp_literal", 32'(cmp_flag), 1);
        chk("t5_pc_literal", 32'(pc), 2);
        read_reg(2'd1, v);
        chk("t5_r1_literal", 32'(v), 5);
        read_reg(2'd0, v);
        chk("t5_r0_literal", 32'(v), 0);

        // run through pc=255 and wrap; imem[0] is swapped for a last instruction after first use
        do_reset();
        for (int i = 0; i < 256; i++) imem[i] = 8'b010_00_00_0;
        imem[255] = 8'b000_01_01_0;
        patch_val = 8'b000_10_10_1;
        patch_en  = 1'b1;
        preload(2'd1, 8'd1, 1'b1);
        preload(2'd2, 8'd4, 1'b1);
        run_prog(3000, 1'b0, 1'b0, 2'd0, 8'd0, cyc);
        check_all("t6", 1'b0);
        chk("t6_pc_literal", 32'(pc), 1);
        read_reg(2'd1, v);
        chk("t6_r1_literal", 32'(v), 2);
        read_reg(2'd2, v);
        chk("t6_r2_literal", 32'(v), 8);

        // ALU never completes: trap after 15 WAIT cycles, then start and preload ignored
        do_reset();
        done_never = 1'b1;
        imem[0] = 8'b101_00_00_1;
        run_prog(100, 1'b0, 1'b0, 2'd0, 8'd0, cyc);
        chk("t7_err_cycle", 32'(cyc), 19);
        check_all("t7", 1'b1);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        preload(2'd0, 8'd9, 1'b0);
        @(posedge clk); #1;
        chk("t7_err_sticky", 32'(err), 1);
        chk("t7_busy", 32'(busy), 0);
        check_all("t7_after", 1'b1);

        // reset while waiting on the ALU, then stray ack/done in IDLE
        do_reset();
        preload(2'd1, 8'd3, 1'b1);
        imem[0] = 8'b101_01_01_1;
        @(posedge clk); #1; start = 1'b1; m_pc = '0; m_halt = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("t8_busy_in_wait", 32'(busy), 1);
        do_reset();
        check_reset("t8_reset");
        done_never = 1'b0;
        stray = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        stray = 1'b0;
        @(posedge clk); #1;
        check_reset("t8_stray");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
